nco_waveform_gen: RTL
=====================

# nco_waveform_gen

Consumer side of the phase accumulator: converts each valid 24-bit phase word into a signed 12-bit audio sample (sine, square, triangle or sawtooth). It sits between the phase accumulator and the audio/PWM sample sink. A 3-stage pipeline feeds a 4-entry output FIFO with a valid/ready handshake. Samples are dropped, and flagged, only if the sink stalls long enough to fill the FIFO.

## Interface
- CPU_CLOCK_FREQ, 50_000_000: system clock in Hz. Documentation only; no behaviour depends on it.
- FIFO_DEPTH, 4: output FIFO entries; must be a power of two, at least 2.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- phase  in  24  phase word from the accumulator; sampled only when phase_valid=1.
- phase_valid  in  1  single-cycle strobe qualifying phase.
- wave_sel  in  2  waveform select, sampled with phase: 0 sine, 1 square, 2 triangle, 3 sawtooth.
- sample  out  12  two's-complement sample at the FIFO head; 0 when the FIFO is empty.
- sample_valid  out  1  FIFO non-empty.
- sample_ready  in  1  sink accepts the head sample when sample_valid and sample_ready are both 1 in the same cycle.
- overflow  out  1  sticky; set when a sample is dropped.
- overflow_clr  in  1  clears overflow. A set in the same cycle wins.

## Operation
- Stage 1 (S1): registers phase, wave_sel and valid. Computes p = phase[23:12], quadrant q = phase[23:22], idx = phase[21:14], and LUT address a = q[0] ? ~idx : idx.
- Stage 2 (S2): synchronous ROM read, mag = LUT[a]. The ROM is 256 x 11 bits, unsigned, with LUT[i] = round(2047*sin(pi/2*(i+0.5)/256)). Endpoints: LUT[0]=6, LUT[255]=2047. p and wave_sel are forwarded.
- Stage 3 (S3): selects the waveform and writes it to the FIFO:
  - sine: q[1] ? -mag : +mag.
  - square: p[11] ? -2047 : +2047.
  - triangle: u = p[11] ? ~p[10:0] : p[10:0], then sample = {u,0} - 2048. Range is -2048..+2046.
  - sawtooth: p - 2048, i.e. {~p[11], p[10:0]}.
- The valid bit travels with the data through each stage. The pipeline never stalls.
- FIFO write: an S3-valid sample is written unless the FIFO is full.
  - Exception: when full and a pop occurs in the same cycle, the write is accepted and the count stays FIFO_DEPTH.
  - Otherwise, when full, the sample is discarded and overflow is set.
- FIFO read: pop on sample_valid & sample_ready. The FIFO is show-ahead: sample is the head entry combinationally from FIFO state.
- Write and read pointers wrap modulo FIFO_DEPTH. An extra count bit distinguishes full from empty.
- Pop while empty is ignored.
- wave_sel changes affect only phases sampled after the change. Samples already in flight keep their waveform.

## Timing
- Reset (asynchronous, immediate) clears:
  - all pipeline valids and FIFO pointers/count;
  - overflow=0, sample_valid=0, sample=0.
- Pipeline data registers need no reset.
- Latency: phase_valid high in cycle N puts the sample in the FIFO at the end of cycle N+3. If the FIFO was empty, sample_valid=1 and sample is valid in cycle N+4.
- Throughput: one phase per cycle is accepted. The accumulator nominally strobes once per CPU_CLOCK_FREQ/SAMPLING_RATE cycles.
- Reset asserted while samples are in flight discards them; no sample emerges after reset deasserts.
- overflow holds until overflow_clr or rst.

## Test plan
- Reset: assert rst mid-cycle, with or without a clock edge -> sample=0, sample_valid=0, overflow=0 immediately.
- Sine: sel=0, phases 0x000000, 0x400000, 0x800000, 0xC00000 -> samples 0x006 (+6), 0x7FF (+2047), 0xFFA (-6), 0x801 (-2047). Each has sample_valid exactly 4 cycles after its strobe, with ready=1.
- Other waves:
  - saw 0x000000 -> 0x800, saw 0xFFF000 -> 0x7FF;
  - square 0x7FF000 -> 0x7FF, square 0x800000 -> 0x801;
  - triangle 0x000000 -> 0x800, triangle 0x7FF000 -> 0x7FE (+2046), triangle 0x800000 -> 0x7FE.
- Backpressure: ready=0, five sawtooth strobes with phases 0x000000, 0x100000, 0x200000, 0x300000, 0x400000 -> four stored and overflow=1 after the fifth. Then ready=1 drains 0x800, 0x900, 0xA00, 0xB00 in order, and sample_valid falls.
- Full with simultaneous pop: FIFO full, a sample reaches S3 in the same cycle as a pop -> no drop, overflow stays 0, count stays 4. overflow_clr asserted in the same cycle as a drop -> overflow=1.
- Reset mid-pipeline: strobe in cycle N, rst pulse in cycle N+2 -> sample_valid stays 0 for 10 cycles after release.

Source files
------------

// File: rtl/nco_waveform_gen.sv
// Phase-to-sample converter: quarter-wave sine ROM, square, triangle, sawtooth.
// Three-stage pipeline into a show-ahead output FIFO with sticky overflow.
module nco_waveform_gen #(
  parameter int CPU_CLOCK_FREQ = 50_000_000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] phase,
  input  logic        phase_valid,
  input  logic [1:0]  wave_sel,
  output logic [11:0] sample,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overflow,
  input  logic        overflow_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      CPU_CLOCK_FREQ <= 0) begin : g_bad_param
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  function automatic logic [10:0] lut_val(input int i);
    real x;
    x = 2047.0 * $sin(3.141592653589793 / 2.0 *
                      (real'(i) + 0.5) / 256.0);
    return 11'($rtoi(x + 0.5));
  endfunction

  logic [10:0] rom [256];
  for (genvar i = 0; i < 256; i++) begin : g_rom
    localparam logic [10:0] V = lut_val(i);
    assign rom[i] = V;
  end

  logic        unused_lo;
  assign unused_lo = ^phase[11:0];

  logic        v1_q, v2_q, v3_q;
  logic [11:0] p1_q, p2_q;
  logic [1:0]  sel1_q, sel2_q;
  logic [10:0] mag_q;
  logic [11:0] s3_q, s3_d;
  logic [7:0]  a1;
  logic [10:0] u2;

  // odd quadrants run the quarter-wave table backwards
  assign a1 = p1_q[10] ? ~p1_q[9:2] : p1_q[9:2];
  assign u2 = p2_q[11] ? ~p2_q[10:0] : p2_q[10:0];

  always_comb begin
    s3_d = '0;
    unique case (sel2_q)
      2'd0: s3_d = p2_q[11] ? 12'd0 - {1'b0, mag_q}
                            : {1'b0, mag_q};
      2'd1: s3_d = p2_q[11] ? 12'h801 : 12'h7FF;
      2'd2: s3_d = {~u2[10], u2[9:0], 1'b0};
      2'd3: s3_d = {~p2_q[11], p2_q[10:0]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v1_q <= phase_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  always_ff @(posedge clk) begin
    p1_q   <= phase[23:12];
    sel1_q <= wave_sel;
    p2_q   <= p1_q;
    sel2_q <= sel1_q;
    mag_q  <= rom[a1];
    s3_q   <= s3_d;
  end

  logic [11:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          empty, full, pop, push, drop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign pop   = !empty && sample_ready;
  // a pop frees the slot the incoming sample needs
  assign push  = v3_q && (!full || pop);
  assign drop  = v3_q && full && !pop;

  always_comb begin
    wr_d  = wr_q + AW'(push);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    ovf_d = ovf_q;
    if (overflow_clr) ovf_d = 1'b0;
    if (drop)         ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= s3_q;
  end

  assign sample       = empty ? 12'd0 : mem_q[rd_q];
  assign sample_valid = !empty;
  assign overflow     = ovf_q;

endmodule
